// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester round-robin arbiter.
//
// Contents:
//   N_REQ, IDX_W  - requester count and grant-index width
//   arb_state_t   - arbiter FSM states (IDLE, GRANT)
//   hold_cnt_w()  - hold-counter width for a given maximum hold length
//   enc_8to3()    - the shared 8:3 one-hot to binary encoder
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Counter must be able to hold the value max_hold itself.
  function automatic int hold_cnt_w(input int max_hold);
    return $clog2(max_hold + 1);
  endfunction

  // One-hot to binary. An all-zero input encodes to 0, which is exactly
  // what the arbiter wants for gnt_idx when nothing is granted.
  function automatic logic [IDX_W-1:0] enc_8to3(input logic [N_REQ-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick_8.sv
// Combinational rotating-priority picker for eight requesters.
//
// Ports:
//   req   [7:0] in  - request vector
//   ptr   [2:0] in  - highest-priority position for this arbitration
//   win   [7:0] out - one-hot winner (all zero when req is zero)
//   found       out - at least one request present
//
// The request vector is rotated so that bit ptr lands on bit 0, the lowest
// set bit is isolated with the x & -x trick, and the result is rotated back.
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [7:0] win,
  output logic       found
);

  logic [N_REQ-1:0] rot_req;
  logic [N_REQ-1:0] rot_win;

  // Index arithmetic is IDX_W bits wide, so it wraps modulo 8 for free.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot_in
    assign rot_req[gi] = req[IDX_W'(gi) + ptr];
  end

  assign rot_win = rot_req & (~rot_req + 8'd1);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot_out
    assign win[gi] = rot_win[IDX_W'(gi) - ptr];
  end

  assign found = |req;

endmodule

// File: rtl/rr_arbiter_8to3.sv
// Eight-requester round-robin arbiter with registered one-hot grant and
// binary grant index.
//
// Parameters:
//   N_REQ    - number of requesters, must be 8
//   MAX_HOLD - maximum consecutive grant cycles (>= 1), only with timeout
//
// Ports:
//   clk             in  - clock, rising edge
//   rst             in  - asynchronous active-high reset
//   req       [7:0] in  - request vector
//   gnt       [7:0] out - registered one-hot grant or zero
//   gnt_idx   [2:0] out - binary index of gnt, 0 when no grant
//   gnt_valid       out - gnt is non-zero
//
// Build option: define RR_ARB_TIMEOUT_EN to add a hold counter that revokes
// a grant after MAX_HOLD cycles. Without it a grant lasts until its request
// drops.
//
// Every release (voluntary or revoked) passes through one IDLE cycle before
// the next grant, giving the downstream stage a turnaround cycle.
module rr_arbiter_8to3
  import arb_pkg::*;
#(
  parameter int N_REQ    = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid
);

  if (N_REQ != 8) begin : g_bad_n_req
    $error("rr_arbiter_8to3 supports N_REQ = 8 only");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("rr_arbiter_8to3 requires MAX_HOLD >= 1");
  end

  arb_state_t state_reg, state_next;
  logic [2:0] ptr_reg,   ptr_next;
  logic [7:0] gnt_reg,   gnt_next;
  logic [2:0] idx_reg,   idx_next;
  logic       valid_reg, valid_next;

  logic [7:0] pick_win;
  logic       pick_found;
  logic [2:0] pick_idx;
  logic       winner_req;
  logic       hold_expired;

  rr_pick_8 u_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .win   (pick_win),
    .found (pick_found)
  );

  assign pick_idx = enc_8to3(pick_win);

  // gnt_reg is one-hot, so this is simply req[w] for the current winner.
  assign winner_req = |(req & gnt_reg);

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HOLD_W = hold_cnt_w(MAX_HOLD);

  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;

  // Counter is 1 in the first grant cycle, so reaching MAX_HOLD means the
  // winner has held for MAX_HOLD cycles and must give way at this edge.
  assign hold_expired = (hold_cnt_reg >= HOLD_W'(MAX_HOLD));
`else
  assign hold_expired = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    valid_next = valid_reg;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_next = hold_cnt_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next = GRANT;
          gnt_next   = pick_win;
          idx_next   = pick_idx;
          valid_next = 1'b1;
          ptr_next   = pick_idx + 3'd1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_next = HOLD_W'(1);
`endif
        end
      end

      GRANT: begin
        if (winner_req && !hold_expired) begin
`ifdef RR_ARB_TIMEOUT_EN
          if (hold_cnt_reg != '1) begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
`endif
        end else begin
          // Release or revoke; ptr already points past the old winner.
          state_next = IDLE;
          gnt_next   = 8'h00;
          idx_next   = 3'd0;
          valid_next = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_next = '0;
`endif
        end
      end

      default: begin
        state_next = IDLE;
        gnt_next   = 8'h00;
        idx_next   = 3'd0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 3'd0;
      gnt_reg   <= 8'h00;
      idx_reg   <= 3'd0;
      valid_reg <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
      valid_reg <= valid_next;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_reg <= hold_cnt_next;
`endif
    end
  end

  assign gnt       = gnt_reg;
  assign gnt_idx   = idx_reg;
  assign gnt_valid = valid_reg;

endmodule

// File: tb/tb_rr_arbiter_8to3.sv
// Directed testbench for rr_arbiter_8to3.
// Each stimulus step drives req and queues the outputs expected after the
// next rising edge; an independent monitor pops and compares one entry per
// cycle. Build with RR_ARB_TIMEOUT_EN defined to exercise the timeout path
// (MAX_HOLD = 4).
module tb_rr_arbiter_8to3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int HOLD_CYC = 3;  // grant cycle + 3 = MAX_HOLD cycles
`else
  localparam int HOLD_CYC = 10;
`endif

  typedef struct packed {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
  } exp_t;

  exp_t sb_q[$];

  rr_arbiter_8to3 #(
    .N_REQ    (8),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  // Drive r shortly after a rising edge; expect (eg, ei) after the next edge.
  task automatic cyc(input logic [7:0] r, input logic [7:0] eg, input logic [2:0] ei);
    exp_t e;
    @(posedge clk);
    #2;
    req     = r;
    e.req   = r;
    e.gnt   = eg;
    e.idx   = ei;
    e.valid = (eg != 8'h00);
    sb_q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({gnt, gnt_idx, gnt_valid} !== 12'h000) begin
      errors++;
      $display("FAIL %s: gnt=%h idx=%0d valid=%b, required all zero", name, gnt, gnt_idx, gnt_valid);
    end else begin
      $display("%s: outputs zero", name);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if ({gnt, gnt_idx, gnt_valid} !== {e.gnt, e.idx, e.valid}) begin
          errors++;
          $display("FAIL txn %0d req=%h: gnt/idx/valid got %h/%0d/%b required %h/%0d/%b",
                   txn, e.req, gnt, gnt_idx, gnt_valid, e.gnt, e.idx, e.valid);
        end else begin
          $display("txn %0d req=%h gnt=%h idx=%0d valid=%b", txn, e.req, gnt, gnt_idx, gnt_valid);
        end
        txn++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #3 rst = 1'b1;
    #4 check_zero("reset_state");
    #15 rst = 1'b0;

    // Async reset in the middle of a grant to idx 2
    cyc(8'h04, 8'h04, 3'd2);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_zero("async_rst_mid_grant");
    req = 8'h00;
    #1 rst = 1'b0;

    // Idle: no requests for 5 cycles
    repeat (5) cyc(8'h00, 8'h00, 3'd0);

    // Single request and release (ptr 0 -> 6)
    cyc(8'h20, 8'h20, 3'd5);
    cyc(8'h00, 8'h00, 3'd0);

    // Bring ptr to 0 via a grant to idx 7
    cyc(8'h80, 8'h80, 3'd7);
    cyc(8'h00, 8'h00, 3'd0);

    // Rotation: all request, winner drops for one cycle then returns
    for (int i = 0; i < 9; i++) begin
      cyc(8'hFF, 8'(1) << (i % 8), 3'(i % 8));
      cyc(8'hFF & ~(8'(1) << (i % 8)), 8'h00, 3'd0);
    end
    // ptr is now 1

    // Wrap-around
    cyc(8'h40, 8'h40, 3'd6);   // ptr -> 7
    cyc(8'h00, 8'h00, 3'd0);
    cyc(8'h03, 8'h01, 3'd0);   // search 7,0 -> idx 0, ptr -> 1
    cyc(8'h00, 8'h00, 3'd0);
    cyc(8'h81, 8'h80, 3'd7);   // search 1..7 -> idx 7, ptr -> 0
    cyc(8'h00, 8'h00, 3'd0);

    // Hold and ignore other requesters
    cyc(8'h04, 8'h04, 3'd2);   // ptr -> 3
    for (int i = 0; i < HOLD_CYC; i++) begin
      cyc(8'hFF, 8'h04, 3'd2);
    end
    cyc(8'h00, 8'h00, 3'd0);

    // Bring ptr back to 0
    cyc(8'h80, 8'h80, 3'd7);
    cyc(8'h00, 8'h00, 3'd0);

    // Long hold with req = 8'h09
    cyc(8'h09, 8'h01, 3'd0);   // ptr -> 1
`ifdef RR_ARB_TIMEOUT_EN
    repeat (3) cyc(8'h09, 8'h01, 3'd0);
    cyc(8'h09, 8'h00, 3'd0);   // revoked after 4 cycles
    cyc(8'h09, 8'h08, 3'd3);   // idx 3 next, ptr -> 4
    // Sole requester: revoked, one idle cycle, re-granted
    repeat (3) cyc(8'h08, 8'h08, 3'd3);
    cyc(8'h08, 8'h00, 3'd0);
    cyc(8'h08, 8'h08, 3'd3);
`else
    repeat (8) cyc(8'h09, 8'h01, 3'd0);
`endif
    cyc(8'h00, 8'h00, 3'd0);

    // Drain the scoreboard (bounded)
    repeat (2) @(posedge clk);
    #3;
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8to3.md
# rr_arbiter_8to3

Eight-requester round-robin arbiter that shares one downstream resource and issues a registered one-hot grant plus its 3-bit binary index. Grants are held while the winner keeps its request high. Priority rotates past each winner. Sits in front of the shared encode/datapath stage and drives its select lines from `gnt_idx`.

## Interface
- `N_REQ`, 8: number of requesters; fixed at 8, other values unsupported.
- `MAX_HOLD`, 16: maximum consecutive grant cycles, ≥1. Used only when `RR_ARB_TIMEOUT_EN` is defined.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input 8: request vector; bit i high means requester i wants the resource.
- `gnt` output 8: registered one-hot grant, or all zero.
- `gnt_idx` output 3: binary index of the asserted `gnt` bit; 0 when `gnt_valid` is low.
- `gnt_valid` output 1: high iff `gnt` is non-zero.

## Operation
- State machine with two states:
  - IDLE: no grant.
  - GRANT: one requester holds the resource.
- Reset (async, effective immediately, any state including mid-grant):
  - state = IDLE, `gnt` = 8'h00, `gnt_idx` = 3'd0, `gnt_valid` = 0.
  - Rotating pointer `ptr` = 3'd0; hold counter = 0.
- IDLE, `req` == 0: stay in IDLE, outputs remain zero.
- IDLE, `req` != 0:
  - Pick the first set bit searching `ptr`, `ptr`+1, … with wrap-around modulo 8.
  - Winner w: `gnt` = 1<<w, `gnt_idx` = w, `gnt_valid` = 1.
  - `ptr` ← (w+1) mod 8, so w becomes lowest priority for the next arbitration.
  - Hold counter ← 1; go to GRANT.
- GRANT, `req[w]` still high: hold the grant unchanged; hold counter increments and saturates.
  - Requests on other bits are ignored, including ones that appear or drop.
- GRANT, `req[w]` low: release. Clear all outputs and return to IDLE.
- After any release there is exactly one IDLE cycle before the next grant, even with requests pending. This gives the downstream resource a guaranteed turnaround cycle.
- `req` bits that toggle while in IDLE are sampled only at the arbitration edge; no latching of past requests.

## Timing
- Grant latency: `req` high before edge k, with state IDLE at k → `gnt` valid after edge k (one cycle).
- Release latency: `req[w]` low before edge k → `gnt` zero after edge k. The earliest next grant is after edge k+1.
- All outputs come straight from flops; no combinational path from `req` to any output.
- Steady-state throughput with several requesters continuously asking: one grant per (hold + 1) cycles.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - In GRANT, when the hold counter reaches `MAX_HOLD` with `req[w]` still high, the grant is revoked at the next edge, identically to a release.
  - The revoked requester stays lowest priority through `ptr`.
  - If it is the only requester, it is re-granted after the single IDLE cycle.
- `RR_ARB_TIMEOUT_EN` undefined:
  - No hold counter is built; a grant lasts until its request drops.
  - `MAX_HOLD` is ignored.

## Structure
- Shared package `arb_pkg`:
  - `N_REQ` = 8 and `IDX_W` = 3.
  - State enum `arb_state_t` {IDLE, GRANT}.
  - Hold-counter width: `$clog2(MAX_HOLD+1)`.
- Sub-module `rr_pick_8`: combinational rotating-priority picker. Takes `req` and `ptr`, returns a one-hot winner and a `found` flag.
- The one-hot winner is converted to `gnt_idx` with the team's existing 8:3 binary encoder before registering.

## Test plan
- Reset then idle:
  - Assert `rst` mid-grant (`gnt`=8'h04) → all outputs zero with no clock edge.
  - `req`=8'h00 for 5 cycles → outputs stay zero.
- Single request:
  - `req`=8'h20 → after one edge `gnt`=8'h20, `gnt_idx`=5, `gnt_valid`=1.
  - Drop `req` → next edge, outputs zero.
- Rotation:
  - `req`=8'hFF held, each winner dropping its bit one cycle after grant, then reasserting.
  - Required grant order: idx 0,1,2,…,7,0, with one IDLE cycle between grants.
- Wrap-around:
  - After a grant to idx 6 (`ptr`=7), present `req`=8'h03 → `gnt_idx`=0, then `ptr`=1.
  - Next `req`=8'h81 → `gnt_idx`=7.
- Hold and ignore:
  - With idx 2 granted, raise `req`=8'hFF for 10 cycles → `gnt` stays 8'h04 throughout.
- Timeout (`RR_ARB_TIMEOUT_EN`, `MAX_HOLD`=4):
  - `req`=8'h09 held → idx 0 granted for 4 cycles, 1 idle cycle, then idx 3 granted.
  - Without the macro: idx 0 is held indefinitely.
